// File: rtl/bht_update_scheduler.sv
// Owns the shared BHT port for non-fetch traffic: sweeps the table to INIT_STATE after reset/flush,
// then drains queued branch outcomes as saturating-counter read-modify-writes when fetch is idle.
module bht_update_scheduler #(
  parameter int         INDEX_WIDTH = 10,
  parameter int         QUEUE_DEPTH = 4,
  parameter logic [1:0] INIT_STATE  = 2'b01
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   upd_valid_d,
  input  logic [INDEX_WIDTH-1:0] upd_index_d,
  input  logic                   upd_taken_d,
  output logic                   upd_ready,
  input  logic                   fetch_port_busy,
  output logic [INDEX_WIDTH-1:0] bht_index,
  input  logic [1:0]             bht_rstate,
  output logic                   bht_we,
  output logic [1:0]             bht_wstate,
  output logic                   init_busy,
  output logic                   state_dbg
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_e;

  // Handshake: an update transfers in a cycle where upd_valid_d & en & upd_ready are all high.
  // upd_ready depends only on registered state, so decode never sees a combinational loop.

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
  logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;
  logic [INDEX_WIDTH-1:0] last_index_q;
  logic [INDEX_WIDTH-1:0] q_index_q [QUEUE_DEPTH];
  logic                   q_taken_q [QUEUE_DEPTH];

  logic                   push, pop, we_int;
  logic [INDEX_WIDTH-1:0] index_int;
  logic [1:0]             wstate_int;

  assign upd_ready = (state_q == S_RUN) && (count_q != CW'(QUEUE_DEPTH));
  assign init_busy = (state_q == S_INIT);
  assign state_dbg = state_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    push       = 1'b0;
    pop        = 1'b0;
    we_int     = 1'b0;
    index_int  = last_index_q;
    wstate_int = INIT_STATE;
    case (state_q)
      S_INIT: begin
        we_int    = 1'b1;
        index_int = ptr_q;
        if (flush) begin
          ptr_d = '0;
        end else begin
          ptr_d = ptr_q + INDEX_WIDTH'(1);
          if (ptr_q == {INDEX_WIDTH{1'b1}}) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (flush) begin
          // Pending updates target a table that is about to be rewritten, so they are discarded.
          state_d = S_INIT;
          ptr_d   = '0;
          head_d  = '0;
          tail_d  = '0;
          count_d = '0;
        end else begin
          pop  = (count_q != '0) && !fetch_port_busy;
          push = upd_valid_d && en && upd_ready;
          if (pop) begin
            we_int    = 1'b1;
            index_int = q_index_q[head_q];
            if (q_taken_q[head_q])
              wstate_int = (bht_rstate == 2'b11) ? 2'b11 : bht_rstate + 2'd1;
            else
              wstate_int = (bht_rstate == 2'b00) ? 2'b00 : bht_rstate - 2'd1;
            head_d = head_q + PW'(1);
          end
          if (push) tail_d = tail_q + PW'(1);
          count_d = count_q + CW'(push) - CW'(pop);
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // The write strobe is masked by rst so it drops the instant reset asserts.
  assign bht_we     = we_int && !rst;
  assign bht_index  = index_int;
  assign bht_wstate = wstate_int;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_INIT;
      ptr_q        <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      last_index_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (we_int) last_index_q <= index_int;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_index_q[tail_q] <= upd_index_d;
      q_taken_q[tail_q] <= upd_taken_d;
    end
  end

endmodule
